// File: rtl/and_or_result_checker.sv
// Clocked checker for an and2 gate (y=a&b, z=a|b): compares each accepted sample against the
// golden AND/OR, counts mismatches, tracks input coverage and reports pass/fail per run.
module and_or_result_checker #(
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [3:0]       cov,
    output logic             all_covered,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_VECTORS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [3:0]       cov_q, cov_d;
    logic             pass_q, pass_d;
    logic             err_pulse_q, err_pulse_d;

    logic accept;
    logic unknown_in;
    logic unknown_ab;
    logic mismatch;

    // Any X/Z on the sample is a mismatch, even where the golden value would mask it.
    assign unknown_in = ((^{a, b, y, z}) === 1'bx);
    assign unknown_ab = ((^{a, b}) === 1'bx);
    assign mismatch   = unknown_in || (y != (a & b)) || (z != (a | b));

    assign in_ready = (state_q == StRun);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d         = state_q;
        err_count_d     = err_count_q;
        vec_count_d     = vec_count_q;
        first_err_idx_d = first_err_idx_q;
        cov_d           = cov_q;
        pass_d          = pass_q;
        err_pulse_d     = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d         = StRun;
                    err_count_d     = '0;
                    vec_count_d     = '0;
                    first_err_idx_d = CntMax;
                    cov_d           = 4'h0;
                    pass_d          = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    vec_count_d = vec_count_q + 1'b1;
                    if (!unknown_ab) begin
                        cov_d[{a, b}] = 1'b1;
                    end
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CntMax) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (first_err_idx_q == CntMax) begin
                            first_err_idx_d = vec_count_q;
                        end
                    end
                    if (vec_count_q == LastIdx) begin
                        state_d = StDone;
                        pass_d  = (err_count_d == '0) && (cov_d == 4'hF);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            err_count_q     <= '0;
            vec_count_q     <= '0;
            first_err_idx_q <= CntMax;
            cov_q           <= 4'h0;
            pass_q          <= 1'b0;
            err_pulse_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_count_q     <= err_count_d;
            vec_count_q     <= vec_count_d;
            first_err_idx_q <= first_err_idx_d;
            cov_q           <= cov_d;
            pass_q          <= pass_d;
            err_pulse_q     <= err_pulse_d;
        end
    end

    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign pass          = pass_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign vec_count     = vec_count_q;
    assign cov           = cov_q;
    assign all_covered   = &cov_q;
    assign first_err_idx = first_err_idx_q;

endmodule
